// File: rtl/icache_mem_responder.sv
// icache_mem_responder: memory-side line-fill responder for the icache.
// Accepts a line request, reads BEATS words from the backing bus, assembles
// the line on mem2icache_data_o and returns a one-cycle ack. Handles kill or
// request retraction mid-fill without ever retracting an outstanding backing read.
// Optional feature: define ICACHE_RESP_LBUF_EN for a one-entry line buffer that
// answers a repeat request for the last completed line without backing access.
module icache_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  icache2mem_req_i,
  input  logic                  icache2mem_kill_i,
  input  logic [ADDR_WIDTH-1:0] icache2mem_addr_i,
  output logic                  mem2icache_ack_o,
  output logic [LINE_WIDTH-1:0] mem2icache_data_o,
  input  logic                  lbuf_inval_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned BEATS    = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned CNT_W    = $clog2(BEATS);
  localparam int unsigned LINE_OFF = $clog2(LINE_WIDTH / 8);
  localparam int unsigned WORD_OFF = $clog2(WORD_WIDTH / 8);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] data_q;

  logic [ADDR_WIDTH-1:0] req_base_c;
  logic                  abort_c;
  logic                  beat_we_c;
  logic                  lbuf_hit_c;
  logic                  lbuf_set_c;
  logic                  lbuf_clr_c;

  assign req_base_c = icache2mem_addr_i & LINE_MASK;
  assign abort_c    = icache2mem_kill_i | ~icache2mem_req_i;
  // A beat is kept only if the fill is still wanted in the cycle its data arrives
  assign beat_we_c  = (state_q == FILL) & mem_ack_i & ~abort_c;

  // Next-state, beat counter and backing-bus request computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    lbuf_set_c = 1'b0;
    lbuf_clr_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (icache2mem_req_i && !icache2mem_kill_i) begin
          base_d = req_base_c;
          cnt_d  = '0;
          if (lbuf_hit_c) begin
            state_d = RESP;
          end else begin
            state_d    = FILL;
            lbuf_clr_c = 1'b1;
          end
        end
      end
      FILL: begin
        if (abort_c) begin
          lbuf_clr_c = 1'b1;
          state_d    = mem_ack_i ? IDLE : DRAIN;
        end else if (mem_ack_i) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RESP: begin
        lbuf_set_c = 1'b1;
        state_d    = IDLE;
      end
      DRAIN: begin
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    mem_req_d  = (state_d == FILL) || (state_d == DRAIN);
    mem_addr_d = mem_req_d ? (base_d + (ADDR_WIDTH'(cnt_d) << WORD_OFF)) : '0;
  end

  // State, counter and registered backing-bus outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Line assembly: each accepted beat lands in its word slot of the line
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (beat_we_c && (cnt_q == CNT_W'(b))) begin
          data_q[b*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata_i;
        end
      end
    end
  end

`ifdef ICACHE_RESP_LBUF_EN
  logic lbuf_valid_q;

  // data_q doubles as the buffered line; base_q is its tag
  assign lbuf_hit_c = lbuf_valid_q & (base_q == req_base_c) & ~lbuf_inval_i;

  // Line buffer valid: invalidate and abort/miss take priority over set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lbuf_valid_q <= 1'b0;
    end else if (lbuf_inval_i || lbuf_clr_c) begin
      lbuf_valid_q <= 1'b0;
    end else if (lbuf_set_c) begin
      lbuf_valid_q <= 1'b1;
    end
  end
`else
  logic unused_lbuf;

  assign lbuf_hit_c  = 1'b0;
  assign unused_lbuf = lbuf_inval_i | lbuf_set_c | lbuf_clr_c;
`endif

  // Ack reflects the requester's intent in the RESP cycle itself
  assign mem2icache_ack_o  = (state_q == RESP) & icache2mem_req_i & ~icache2mem_kill_i;
  assign mem2icache_data_o = data_q;
  assign mem_req_o         = mem_req_q;
  assign mem_addr_o        = mem_addr_q;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Randomized transaction-level bench for icache_mem_responder (4 x 32-bit beats).
module tb_icache_mem_responder;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req;
  logic         kill;
  logic [31:0]  addr;
  logic         ack;
  logic [127:0] line_data;
  logic         inval;
  logic         mreq;
  logic [31:0]  maddr;
  logic         mack;
  logic [31:0]  rdata;

  int n_total = 0;
  int n_bad   = 0;
  int waits [4];
  logic [31:0] salt;
  int lat;

`ifdef ICACHE_RESP_LBUF_EN
  localparam bit LBUF = 1'b1;
  bit           lb_valid = 1'b0;
  logic [31:0]  lb_tag   = '0;
  logic [127:0] lb_line  = '0;
`else
  localparam bit LBUF = 1'b0;
`endif

  icache_mem_responder dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .icache2mem_req_i  (req),
    .icache2mem_kill_i (kill),
    .icache2mem_addr_i (addr),
    .mem2icache_ack_o  (ack),
    .mem2icache_data_o (line_data),
    .lbuf_inval_i      (inval),
    .mem_req_o         (mreq),
    .mem_addr_o        (maddr),
    .mem_ack_i         (mack),
    .mem_rdata_i       (rdata)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Backing memory contents: a fixed function of address, varied per transaction by salt
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // One icache line request; abort at (ab_beat, ab_idx) if ab_beat >= 0.
  // lat returns the ack cycle relative to the accept cycle, or -1 if never acked.
  task automatic run_txn(input logic [31:0] a, input bit inv, input int ab_beat,
                         input int ab_idx, input bit ab_kill, input int drain, output int lat_o);
    logic [31:0]  base;
    logic [127:0] line;
    int           cyc;
    bit           aborted, ab_ack, hit;
    base = a & 32'hFFFF_FFF0;
    line = '0; cyc = 0; aborted = 0; ab_ack = 0; hit = 0; lat_o = -1;
    @(negedge clk_i);
    req = 1'b1; kill = 1'b0; addr = a; inval = inv; mack = 1'b0; rdata = $urandom;
    #1;
    check("accept_mreq", 128'(mreq), 128'(0));
    check("accept_ack", 128'(ack), 128'(0));
`ifdef ICACHE_RESP_LBUF_EN
    hit = lb_valid && (lb_tag == base) && !inv;
    if (!hit) lb_valid = 1'b0;
`endif
    if (hit) begin
      @(negedge clk_i);
      inval = 1'b0; cyc = 1;
      #1;
      check("hit_ack", 128'(ack), 128'(1));
      check("hit_mreq", 128'(mreq), 128'(0));
`ifdef ICACHE_RESP_LBUF_EN
      check("hit_data", line_data, lb_line);
`endif
      lat_o = cyc;
    end else begin
      for (int k = 0; k < 4 && !aborted; k++) begin
        for (int i = 0; i <= waits[k] && !aborted; i++) begin
          @(negedge clk_i);
          cyc++; inval = 1'b0;
          mack  = (i == waits[k]);
          rdata = mack ? mem_word(base + 32'(4 * k)) : $urandom;
          if (k == ab_beat && i == ab_idx) begin
            aborted = 1'b1; ab_ack = mack;
            if (ab_kill) kill = 1'b1; else req = 1'b0;
          end
          #1;
          check("fill_mreq", 128'(mreq), 128'(1));
          check("fill_addr", 128'(maddr), 128'(base + 32'(4 * k)));
          check("fill_ack", 128'(ack), 128'(0));
          if (!aborted && mack) line[k*32 +: 32] = rdata;
        end
      end
      if (aborted) begin
        if (!ab_ack) begin
          for (int d = 0; d <= drain; d++) begin
            @(negedge clk_i);
            req = 1'b0; kill = 1'($urandom_range(0, 1)); mack = (d == drain); rdata = $urandom;
            #1;
            check("drain_mreq", 128'(mreq), 128'(1));
            check("drain_addr", 128'(maddr), 128'(base + 32'(4 * ab_beat)));
            check("drain_ack", 128'(ack), 128'(0));
          end
        end
        @(negedge clk_i);
        req = 1'b0; kill = 1'b0; mack = 1'b0;
        #1;
        check("abort_mreq", 128'(mreq), 128'(0));
        check("abort_ack", 128'(ack), 128'(0));
      end else begin
        @(negedge clk_i);
        mack = 1'b0; rdata = $urandom; cyc++;
        #1;
        check("resp_ack", 128'(ack), 128'(1));
        check("resp_data", line_data, line);
        check("resp_mreq", 128'(mreq), 128'(0));
        lat_o = cyc;
`ifdef ICACHE_RESP_LBUF_EN
        lb_valid = 1'b1; lb_tag = base; lb_line = line;
`endif
      end
    end
    if (!aborted) begin
      @(negedge clk_i);
      req = 1'b0; kill = 1'b0;
      #1;
      check("post_ack", 128'(ack), 128'(0));
      check("post_mreq", 128'(mreq), 128'(0));
    end
  endtask

  initial begin
    int ab_beat;
    req = 1'b0; kill = 1'b0; addr = '0; inval = 1'b0; mack = 1'b0; rdata = '0;
    salt = 32'h1234_5678;
    rst_ni = 1'b0;
    #12;
    check("rst_ack", 128'(ack), 128'(0));
    check("rst_mreq", 128'(mreq), 128'(0));
    check("rst_maddr", 128'(maddr), 128'(0));
    check("rst_data", line_data, 128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Zero-wait fill of 0x8000_0014: beats at 0x..10..1C, ack on cycle 5
    waits = '{0, 0, 0, 0};
    run_txn(32'h8000_0014, 1'b0, -1, 0, 1'b0, 0, lat);
    check("lat_zero_wait", 128'(lat), 128'(5));

    // Same line again: buffered build answers on cycle 1, otherwise a full fill
    run_txn(32'h8000_0010, 1'b0, -1, 0, 1'b0, 0, lat);
    check("lat_repeat", 128'(lat), LBUF ? 128'(1) : 128'(5));
    run_txn(32'h8000_0010, 1'b1, -1, 0, 1'b0, 0, lat);
    check("lat_inval", 128'(lat), 128'(5));

    // Two wait states per beat
    salt = $urandom;
    waits = '{2, 2, 2, 2};
    run_txn(32'h8000_0040, 1'b0, -1, 0, 1'b0, 0, lat);
    check("lat_wait2", 128'(lat), 128'(13));

    // Kill during beat 1 while backing read still pending -> drain
    waits = '{0, 1, 0, 0};
    run_txn(32'h8000_0100, 1'b0, 1, 0, 1'b1, 2, lat);
    check("kill_no_ack", 128'(lat), 128'(-1));

    // Request dropped on beat 3 together with its backing ack
    waits = '{0, 0, 0, 0};
    run_txn(32'h8000_0180, 1'b0, 3, 0, 1'b0, 0, lat);
    check("drop_no_ack", 128'(lat), 128'(-1));

    // Asynchronous reset with beat counter at 2
    @(negedge clk_i);
    req = 1'b1; kill = 1'b0; addr = 32'h8000_0200; inval = 1'b0; mack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      mack = 1'b1; rdata = mem_word(32'h8000_0200 + 32'(4 * k));
    end
    @(negedge clk_i);
    mack = 1'b0;
    #1;
    check("mid_addr", 128'(maddr), 128'(32'h8000_0208));
    rst_ni = 1'b0;
    #1;
    check("mid_rst_mreq", 128'(mreq), 128'(0));
    check("mid_rst_maddr", 128'(maddr), 128'(0));
    check("mid_rst_data", line_data, 128'(0));
    check("mid_rst_ack", 128'(ack), 128'(0));
    @(negedge clk_i);
    req = 1'b0;
    rst_ni = 1'b1;
`ifdef ICACHE_RESP_LBUF_EN
    lb_valid = 1'b0;
`endif
    run_txn(32'h8000_0200, 1'b0, -1, 0, 1'b0, 0, lat);
    check("lat_after_rst", 128'(lat), 128'(5));

    // Random mix of lines, wait states, aborts and invalidates
    for (int t = 0; t < 60; t++) begin
      salt = $urandom;
      for (int k = 0; k < 4; k++) waits[k] = $urandom_range(0, 2);
      ab_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(32'h8000_0000 | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15),
              1'($urandom_range(0, 4) == 0), ab_beat,
              (ab_beat >= 0) ? int'($urandom_range(0, waits[(ab_beat >= 0) ? ab_beat : 0])) : 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 2), lat);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
